toggle_register: RTL and testbench
==================================

# toggle_register

Parametrised, multi-mode register built from per-bit toggle cells, generalising the single-bit T flip-flop to a WIDTH-bit word. Each cycle one mode is applied: masked toggle, masked set/clear, parallel load, binary up/down count, or Gray-code count. It provides registered wrap and change-event pulses. It sits in the lab datapath as the common state element for counters, LED/pattern registers and divider front-ends.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RESET_VALUE, 0, value of q after reset (WIDTH bits)
- SATURATE, 0, 0 = counters wrap; 1 = counters stick at limit
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clock clk
- en  input  1  cycle qualifier; 0 = hold everything
- mode  input  3  operation select (see Operation)
- t_mask  input  WIDTH  per-bit toggle/set/clear mask
- load_val  input  WIDTH  parallel load data
- q  output  WIDTH  register contents
- wrap  output  1  one-cycle pulse: count hit limit (wrapped or saturated)
- changed  output  1  one-cycle pulse: q changed value this edge
- tc  output  1  combinational: q at terminal value for current mode (all-ones for UP/GRAY_UP in binary-decoded sense, zero for DOWN), else 0

## Operation
- Modes, applied on rising clk when en=1:
  - 000 HOLD: q unchanged
  - 001 TOGGLE: q <= q ^ t_mask (bitwise T-FF)
  - 010 SET: q <= q | t_mask
  - 011 CLEAR: q <= q & ~t_mask
  - 100 LOAD: q <= load_val
  - 101 UP: q <= q + 1 (mod 2^WIDTH)
  - 110 DOWN: q <= q − 1 (mod 2^WIDTH)
  - 111 GRAY_UP: q treated as Gray code; q <= gray(bin(q) + 1). Successive values differ in exactly one bit
- en=0: q holds, wrap and changed clear to 0 next edge; mode/t_mask/load_val ignored
- Limits: UP limit q = all-ones; DOWN limit q = 0; GRAY_UP limit bin(q) = all-ones (q = 1 followed by zeros)
- At limit with SATURATE=0: q wraps (UP→0, DOWN→all-ones, GRAY_UP→0); wrap=1 next cycle
- At limit with SATURATE=1: q holds; wrap=1 for every cycle the count is attempted at limit
- wrap never asserts in modes 000–100
- changed = 1 iff new q ≠ old q (e.g. TOGGLE with t_mask=0 gives changed=0; LOAD of the same value gives changed=0)
- All arithmetic WIDTH bits, unsigned; no carry out beyond wrap

## Timing
- Reset asserted (any time, asynchronously): q = RESET_VALUE, wrap = 0, changed = 0 immediately; held while reset=1
- First update on the first rising clk after reset deasserts
- Latency: one clock from mode/en sample to q, wrap, changed; all three update on the same edge
- wrap and changed are single-cycle pulses unless the condition recurs on consecutive edges
- tc is combinational from q and mode (no register); valid the same cycle
- Reset mid-count: count discards, next count starts from RESET_VALUE; no pulse emitted on reset release

## Test plan
- Reset with RESET_VALUE=8'hA5, then en=0 for 3 cycles with mode=101 -> q=8'hA5, wrap=0, changed=0 throughout
- LOAD 8'h0F, TOGGLE t_mask=8'hFF, SET 8'h01, CLEAR 8'h80 -> q=8'h0F, 8'hF0, 8'hF1, 8'h71; changed=1 each cycle; TOGGLE t_mask=0 -> changed=0
- SATURATE=0: LOAD 8'hFE, UP ×3 -> q=8'hFF, 8'h00, 8'h01; wrap=1 only after the FF→00 edge; DOWN from 8'h00 -> 8'hFF, wrap=1
- SATURATE=1: LOAD 8'hFE, UP ×3 -> q=8'hFF, 8'hFF, 8'hFF; wrap=1 on cycles 2 and 3, changed=0 on those cycles; tc=1 while q=8'hFF in UP
- WIDTH=4 GRAY_UP from 0 for 17 cycles -> sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1; each step one-bit change; wrap=1 after 8→0
- Assert reset asynchronously mid-cycle during UP counting at q=8'h37 -> q=RESET_VALUE before next clk edge; counting resumes from RESET_VALUE after release

Source files
------------

// File: rtl/toggle_register_if.sv
//------------------------------------------------------------------------------
// Module   : toggle_register_if
// Purpose  : Control/status bundle for toggle_register.
//            master : drives en, mode, t_mask, load_val; observes q, wrap,
//                     changed, tc
//            slave  : the register itself
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface toggle_register_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] t_mask;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             changed;
    logic             tc;

    modport master (
        output en, mode, t_mask, load_val,
        input  q, wrap, changed, tc
    );

    modport slave (
        input  en, mode, t_mask, load_val,
        output q, wrap, changed, tc
    );
endinterface

`default_nettype wire

// File: rtl/toggle_register.sv
//------------------------------------------------------------------------------
// Module   : toggle_register
// Purpose  : WIDTH-bit multi-mode register built from per-bit toggle cells.
//            Modes: hold, masked toggle, masked set, masked clear, load,
//            binary up, binary down, Gray-code up. Registered wrap/changed
//            pulses, combinational terminal-count flag.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-high
//            bus    - toggle_register_if.slave (en, mode, t_mask, load_val
//                     in; q, wrap, changed, tc out). Interface WIDTH must
//                     match this module's WIDTH.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module toggle_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    toggle_register_if.slave  bus
);

    localparam logic [2:0] c_MODE_HOLD   = 3'b000;
    localparam logic [2:0] c_MODE_TOGGLE = 3'b001;
    localparam logic [2:0] c_MODE_SET    = 3'b010;
    localparam logic [2:0] c_MODE_CLEAR  = 3'b011;
    localparam logic [2:0] c_MODE_LOAD   = 3'b100;
    localparam logic [2:0] c_MODE_UP     = 3'b101;
    localparam logic [2:0] c_MODE_DOWN   = 3'b110;
    localparam logic [2:0] c_MODE_GRAY   = 3'b111;

    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO     = '0;
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_changed;

    logic [WIDTH-1:0] w_bin;        // q decoded from Gray to binary
    logic [WIDTH-1:0] w_bin_inc;
    logic [WIDTH-1:0] w_gray_next;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_toggle;     // bits whose cell must flip this edge
    logic             w_at_limit;   // a count is attempted at its limit
    logic             w_tc;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
    // above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bin
            assign w_bin[gi] = ^r_q[WIDTH-1:gi];
        end
    endgenerate

    assign w_bin_inc   = w_bin + c_ONE;
    assign w_gray_next = w_bin_inc ^ (w_bin_inc >> 1);

    always_comb begin
        w_next     = r_q;
        w_at_limit = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                c_MODE_HOLD:   w_next = r_q;
                c_MODE_TOGGLE: w_next = r_q ^ bus.t_mask;
                c_MODE_SET:    w_next = r_q | bus.t_mask;
                c_MODE_CLEAR:  w_next = r_q & ~bus.t_mask;
                c_MODE_LOAD:   w_next = bus.load_val;
                c_MODE_UP: begin
                    w_at_limit = (r_q == c_ALL_ONES);
                    w_next     = (w_at_limit && SATURATE) ? r_q : r_q + c_ONE;
                end
                c_MODE_DOWN: begin
                    w_at_limit = (r_q == c_ZERO);
                    w_next     = (w_at_limit && SATURATE) ? r_q : r_q - c_ONE;
                end
                c_MODE_GRAY: begin
                    // bin all-ones + 1 rolls over to 0, whose Gray code is 0
                    w_at_limit = (w_bin == c_ALL_ONES);
                    w_next     = (w_at_limit && SATURATE) ? r_q : w_gray_next;
                end
                default:       w_next = r_q;
            endcase
        end
    end

    // Every mode reduces to a per-bit toggle enable, so each bit is a T-FF.
    assign w_toggle = w_next ^ r_q;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q[gi] <= RESET_VALUE[gi];
                end else if (w_toggle[gi]) begin
                    r_q[gi] <= ~r_q[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrap    <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_wrap    <= w_at_limit;
            r_changed <= |w_toggle;
        end
    end

    always_comb begin
        w_tc = 1'b0;
        case (bus.mode)
            c_MODE_UP:   w_tc = (r_q == c_ALL_ONES);
            c_MODE_DOWN: w_tc = (r_q == c_ZERO);
            c_MODE_GRAY: w_tc = (w_bin == c_ALL_ONES);
            default:     w_tc = 1'b0;
        endcase
    end

    assign bus.q       = r_q;
    assign bus.wrap    = r_wrap;
    assign bus.changed = r_changed;
    assign bus.tc      = w_tc;

endmodule

`default_nettype wire

// File: tb/tb_toggle_register.sv
//------------------------------------------------------------------------------
// Module   : tb_toggle_register
// Purpose  : Self-checking bench for toggle_register. Three instances:
//            dut_a (8 bit, reset A5, wrapping), dut_s (8 bit, saturating),
//            dut_g (4 bit, wrapping, Gray sequence).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_toggle_register;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    toggle_register_if #(.WIDTH(8)) if_a ();
    toggle_register_if #(.WIDTH(8)) if_s ();
    toggle_register_if #(.WIDTH(4)) if_g ();

    toggle_register #(.WIDTH(8), .RESET_VALUE(8'hA5), .SATURATE(1'b0))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    toggle_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b1))
        dut_s (.clk(clk), .reset(reset), .bus(if_s));
    toggle_register #(.WIDTH(4), .RESET_VALUE(4'h0), .SATURATE(1'b0))
        dut_g (.clk(clk), .reset(reset), .bus(if_g));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (value-level arithmetic) ----------------
    typedef struct {
        int q;
        bit wrap;
        bit chg;
    } mres_t;

    function automatic int gray2bin(input int g, input int w);
        for (int b = 0; b < (1 << w); b++)
            if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    function automatic mres_t ref_step(input int w, input bit sat, input int q,
                                       input bit en, input int m, input int mask, input int ld);
        mres_t r;
        int top = (1 << w) - 1;
        int nq  = q;
        int b;
        bit lim = 1'b0;
        if (en) begin
            case (m)
                1: nq = q ^ (mask & top);
                2: nq = q | (mask & top);
                3: nq = q & ~mask & top;
                4: nq = ld & top;
                5: begin lim = (q == top); nq = lim ? (sat ? q : 0) : q + 1; end
                6: begin lim = (q == 0);   nq = lim ? (sat ? q : top) : q - 1; end
                7: begin
                    b   = gray2bin(q, w);
                    lim = (b == top);
                    b   = lim ? (sat ? b : 0) : b + 1;
                    nq  = b ^ (b >> 1);
                end
                default: nq = q;
            endcase
        end
        r.q    = nq;
        r.wrap = lim;
        r.chg  = (nq != q);
        return r;
    endfunction

    function automatic bit ref_tc(input int w, input int q, input int m);
        int top = (1 << w) - 1;
        if (m == 5) return q == top;
        if (m == 6) return q == 0;
        if (m == 7) return gray2bin(q, w) == top;
        return 1'b0;
    endfunction

    // ---------------- directed table for dut_a ----------------
    typedef struct {
        bit         en;
        logic [2:0] mode;
        logic [7:0] mask;
        logic [7:0] ld;
        logic [7:0] q;
        bit         wrap;
        bit         chg;
        bit         tc;
    } vec_t;

    function automatic vec_t mk(input bit en, input logic [2:0] mode, input logic [7:0] mask,
                                input logic [7:0] ld, input logic [7:0] q,
                                input bit wrap, input bit chg, input bit tc);
        vec_t v;
        v.en = en; v.mode = mode; v.mask = mask; v.ld = ld;
        v.q = q; v.wrap = wrap; v.chg = chg; v.tc = tc;
        return v;
    endfunction

    logic [3:0] gseq [0:17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};

    initial begin
        vec_t  tbl [$];
        mres_t ra, rs, rg;
        int    mq_a, mq_s, mq_g;
        bit    ren;
        int    rmode, rmask, rld;

        if_a.en = 0; if_a.mode = 3'd0; if_a.t_mask = '0; if_a.load_val = '0;
        if_s.en = 0; if_s.mode = 3'd0; if_s.t_mask = '0; if_s.load_val = '0;
        if_g.en = 0; if_g.mode = 3'd0; if_g.t_mask = '0; if_g.load_val = '0;

        #1 reset = 1'b1;
        #11;
        check("reset_q",       32'(if_a.q), 32'hA5);
        check("reset_wrap",    32'(if_a.wrap), 0);
        check("reset_changed", 32'(if_a.changed), 0);
        @(negedge clk);
        reset = 1'b0;

        tbl.push_back(mk(0, 3'd5, 8'h00, 8'h00, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 3'd5, 8'h00, 8'h00, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(0, 3'd5, 8'h00, 8'h00, 8'hA5, 0, 0, 0));
        tbl.push_back(mk(1, 3'd4, 8'h00, 8'h0F, 8'h0F, 0, 1, 0));
        tbl.push_back(mk(1, 3'd1, 8'hFF, 8'h00, 8'hF0, 0, 1, 0));
        tbl.push_back(mk(1, 3'd2, 8'h01, 8'h00, 8'hF1, 0, 1, 0));
        tbl.push_back(mk(1, 3'd3, 8'h80, 8'h00, 8'h71, 0, 1, 0));
        tbl.push_back(mk(1, 3'd1, 8'h00, 8'h00, 8'h71, 0, 0, 0));
        tbl.push_back(mk(1, 3'd4, 8'h00, 8'hFE, 8'hFE, 0, 1, 0));
        tbl.push_back(mk(1, 3'd5, 8'h00, 8'h00, 8'hFF, 0, 1, 1));
        tbl.push_back(mk(1, 3'd5, 8'h00, 8'h00, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 3'd5, 8'h00, 8'h00, 8'h01, 0, 1, 0));
        tbl.push_back(mk(1, 3'd4, 8'h00, 8'h00, 8'h00, 0, 1, 0));
        tbl.push_back(mk(1, 3'd6, 8'h00, 8'h00, 8'hFF, 1, 1, 0));
        tbl.push_back(mk(1, 3'd4, 8'h00, 8'hFF, 8'hFF, 0, 0, 0));
        tbl.push_back(mk(1, 3'd6, 8'h00, 8'h00, 8'hFE, 0, 1, 0));
        tbl.push_back(mk(0, 3'd6, 8'hFF, 8'h00, 8'hFE, 0, 0, 0));
        tbl.push_back(mk(1, 3'd0, 8'hFF, 8'h12, 8'hFE, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if_a.en = tbl[i].en; if_a.mode = tbl[i].mode;
            if_a.t_mask = tbl[i].mask; if_a.load_val = tbl[i].ld;
            step();
            check($sformatf("tbl%0d_q", i),       32'(if_a.q),       32'(tbl[i].q));
            check($sformatf("tbl%0d_wrap", i),    32'(if_a.wrap),    32'(tbl[i].wrap));
            check($sformatf("tbl%0d_changed", i), 32'(if_a.changed), 32'(tbl[i].chg));
            check($sformatf("tbl%0d_tc", i),      32'(if_a.tc),      32'(tbl[i].tc));
        end
        if_a.en = 0;

        // ---------------- saturating counter ----------------
        if_s.en = 1; if_s.mode = 3'd4; if_s.load_val = 8'hFE;
        step();
        check("sat_load_q", 32'(if_s.q), 32'hFE);
        if_s.mode = 3'd5;
        step();
        check("sat_up1_q", 32'(if_s.q), 32'hFF);
        check("sat_up1_wrap", 32'(if_s.wrap), 0);
        check("sat_up1_changed", 32'(if_s.changed), 1);
        check("sat_up1_tc", 32'(if_s.tc), 1);
        for (int k = 2; k <= 3; k++) begin
            step();
            check($sformatf("sat_up%0d_q", k), 32'(if_s.q), 32'hFF);
            check($sformatf("sat_up%0d_wrap", k), 32'(if_s.wrap), 1);
            check($sformatf("sat_up%0d_changed", k), 32'(if_s.changed), 0);
            check($sformatf("sat_up%0d_tc", k), 32'(if_s.tc), 1);
        end
        if_s.mode = 3'd4; if_s.load_val = 8'h00;
        step();
        check("sat_load0_wrap", 32'(if_s.wrap), 0);
        if_s.mode = 3'd6;
        step();
        check("sat_down_q", 32'(if_s.q), 32'h00);
        check("sat_down_wrap", 32'(if_s.wrap), 1);
        check("sat_down_changed", 32'(if_s.changed), 0);
        check("sat_down_tc", 32'(if_s.tc), 1);
        if_s.en = 0;
        step();
        check("sat_en0_wrap", 32'(if_s.wrap), 0);

        // ---------------- Gray sequence on 4-bit instance ----------------
        if_g.en = 1; if_g.mode = 3'd7;
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] prev;
            prev = if_g.q;
            step();
            check($sformatf("gray%0d_q", k), 32'(if_g.q), 32'(gseq[k]));
            check($sformatf("gray%0d_onebit", k), 32'($countones(prev ^ if_g.q)), 1);
            check($sformatf("gray%0d_wrap", k), 32'(if_g.wrap), (k == 16) ? 1 : 0);
            check($sformatf("gray%0d_tc", k), 32'(if_g.tc), (gseq[k] == 4'h8) ? 1 : 0);
        end
        if_g.en = 0;

        // ---------------- asynchronous reset mid-count ----------------
        if_a.en = 1; if_a.mode = 3'd4; if_a.load_val = 8'h36;
        step();
        if_a.mode = 3'd5;
        step();
        check("async_pre_q", 32'(if_a.q), 32'h37);
        #3 reset = 1'b1;
        #1;
        check("async_q", 32'(if_a.q), 32'hA5);
        check("async_changed", 32'(if_a.changed), 0);
        check("async_wrap", 32'(if_a.wrap), 0);
        step();
        check("async_hold_q", 32'(if_a.q), 32'hA5);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("async_resume_q", 32'(if_a.q), 32'hA6);
        check("async_resume_changed", 32'(if_a.changed), 1);
        check("async_resume_wrap", 32'(if_a.wrap), 0);

        // ---------------- randomized against the model ----------------
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mq_a = 8'hA5; mq_s = 0; mq_g = 0;
        for (int n = 0; n < 400; n++) begin
            ren   = ($urandom_range(0, 7) != 0);
            rmode = $urandom_range(0, 7);
            rmask = $urandom_range(0, 255);
            case ($urandom_range(0, 7))
                0: rld = 8'hFF;
                1: rld = 8'h00;
                2: rld = 8'hFE;
                3: rld = 8'h01;
                default: rld = $urandom_range(0, 255);
            endcase
            if_a.en = ren; if_a.mode = 3'(rmode); if_a.t_mask = 8'(rmask); if_a.load_val = 8'(rld);
            if_s.en = ren; if_s.mode = 3'(rmode); if_s.t_mask = 8'(rmask); if_s.load_val = 8'(rld);
            if_g.en = ren; if_g.mode = 3'(rmode); if_g.t_mask = 4'(rmask); if_g.load_val = 4'(rld);
            ra = ref_step(8, 1'b0, mq_a, ren, rmode, rmask, rld);
            rs = ref_step(8, 1'b1, mq_s, ren, rmode, rmask, rld);
            rg = ref_step(4, 1'b0, mq_g, ren, rmode, rmask, rld);
            mq_a = ra.q; mq_s = rs.q; mq_g = rg.q;
            step();
            check("rnd_a_q", 32'(if_a.q), 32'(ra.q));
            check("rnd_a_wrap", 32'(if_a.wrap), 32'(ra.wrap));
            check("rnd_a_changed", 32'(if_a.changed), 32'(ra.chg));
            check("rnd_a_tc", 32'(if_a.tc), 32'(ref_tc(8, ra.q, rmode)));
            check("rnd_s_q", 32'(if_s.q), 32'(rs.q));
            check("rnd_s_wrap", 32'(if_s.wrap), 32'(rs.wrap));
            check("rnd_s_changed", 32'(if_s.changed), 32'(rs.chg));
            check("rnd_s_tc", 32'(if_s.tc), 32'(ref_tc(8, rs.q, rmode)));
            check("rnd_g_q", 32'(if_g.q), 32'(rg.q));
            check("rnd_g_wrap", 32'(if_g.wrap), 32'(rg.wrap));
            check("rnd_g_changed", 32'(if_g.changed), 32'(rg.chg));
            check("rnd_g_tc", 32'(if_g.tc), 32'(ref_tc(4, rg.q, rmode)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
